draw_test_pattern_gen: RTL and testbench



---
 rtl/draw_test_pattern_gen.sv | 251 +++++++++++++++++++++++++
 tb/tb_draw_test_pattern_gen.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_test_pattern_gen.sv
// Bitmap pixel writer: paints colour bars after reset, then services clear,
// snow and random-pixel requests through a single DDR3 write port.
module draw_test_pattern_gen #(
    parameter int unsigned PORT_ADDR_SIZE = 25,
    parameter int unsigned PIXEL_WIDTH    = 32
) (
    input  logic                        CMD_CLK,
    input  logic                        reset,
    input  logic [2:0]                  DISP_pixel_bytes,
    input  logic [31:0]                 DISP_mem_addr,
    input  logic signed [15:0]          DISP_bitmap_width,
    input  logic signed [15:0]          DISP_bitmap_height,
    input  logic                        write_busy_in,
    output logic                        write_req_out,
    output logic [PORT_ADDR_SIZE-1:0]   write_adr_out,
    output logic [31:0]                 write_data_out,
    output logic [PIXEL_WIDTH/8-1:0]    write_mask_out,
    input  logic [1:0]                  buttons,
    input  logic [1:0]                  switches
);

    localparam int unsigned MASK_W = PIXEL_WIDTH / 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_FILL  = 3'd2;
    localparam logic [2:0] ST_MOD   = 3'd3;
    localparam logic [2:0] ST_PLOT  = 3'd4;

    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_CLEAR = 2'd1;
    localparam logic [1:0] MODE_SNOW  = 2'd2;
    localparam logic [1:0] MODE_PLOT  = 2'd3;

    localparam logic [31:0] LFSR_SEED  = 32'hACE12468;
    localparam logic [31:0] CLEAR_STEP = 32'h00102030;

    logic [2:0]  state_q;
    logic [1:0]  mode_q;
    logic [31:0] lfsr_q;
    logic [31:0] clear_color_q;
    logic [15:0] w_q, h_q;
    logic [2:0]  b_q;
    logic [31:0] base_q, addr_q;
    logic [15:0] x_q, y_q;
    logic [15:0] bar_cnt_q;
    logic [2:0]  bar_idx_q;
    logic [3:0]  mod_cnt_q;
    logic [15:0] sx_q, sy_q, rx_q, ry_q;

    logic              lfsr_fb;
    logic [2:0]        pix_bytes;
    logic              geom_ok;
    logic [15:0]       bar_w;
    logic [31:0]       bar_color, fill_color;
    logic [MASK_W-1:0] byte_mask;
    logic [16:0]       rx_shift, ry_shift, rx_diff, ry_diff;
    logic [15:0]       rx_step, ry_step;
    logic [31:0]       plot_index, plot_offset, plot_addr;
    logic              unused_sw;

    assign unused_sw = switches[1];

    // Geometry decode, LFSR feedback, colour and mask selection
    always_comb begin
        lfsr_fb = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];

        case (DISP_pixel_bytes)
            3'd1:    pix_bytes = 3'd1;
            3'd2:    pix_bytes = 3'd2;
            default: pix_bytes = 3'd4;
        endcase

        geom_ok = !DISP_bitmap_width[15]  && (DISP_bitmap_width  != 16'sd0) &&
                  !DISP_bitmap_height[15] && (DISP_bitmap_height != 16'sd0);

        bar_w = (w_q[15:3] == 13'd0) ? 16'd1 : {3'b000, w_q[15:3]};

        case (bar_idx_q)
            3'd0:    bar_color = 32'hFFFFFFFF;
            3'd1:    bar_color = 32'hFFFFFF00;
            3'd2:    bar_color = 32'hFF00FFFF;
            3'd3:    bar_color = 32'hFF00FF00;
            3'd4:    bar_color = 32'hFFFF00FF;
            3'd5:    bar_color = 32'hFFFF0000;
            3'd6:    bar_color = 32'hFF0000FF;
            default: bar_color = 32'hFF000000;
        endcase

        case (mode_q)
            MODE_CLEAR: fill_color = clear_color_q;
            MODE_SNOW:  fill_color = lfsr_q;
            default:    fill_color = bar_color;
        endcase

        byte_mask = '0;
        for (int i = 0; i < int'(MASK_W); i++) begin
            byte_mask[i] = (i < int'(b_q));
        end
    end

    // One restoring-remainder step per cycle for x and y, plus the plot address
    always_comb begin
        rx_shift = {rx_q, sx_q[15]};
        ry_shift = {ry_q, sy_q[15]};
        rx_diff  = rx_shift - {1'b0, w_q};
        ry_diff  = ry_shift - {1'b0, h_q};
        rx_step  = (rx_shift >= {1'b0, w_q}) ? rx_diff[15:0] : rx_shift[15:0];
        ry_step  = (ry_shift >= {1'b0, h_q}) ? ry_diff[15:0] : ry_shift[15:0];

        plot_index = ({16'd0, ry_q} * {16'd0, w_q}) + {16'd0, rx_q};
        case (b_q)
            3'd1:    plot_offset = plot_index;
            3'd2:    plot_offset = {plot_index[30:0], 1'b0};
            default: plot_offset = {plot_index[29:0], 2'b00};
        endcase
        plot_addr = base_q + plot_offset;
    end

    // Control FSM, cursor, LFSR and registered write port
    always_ff @(posedge CMD_CLK) begin
        if (reset) begin
            state_q        <= ST_SETUP;
            mode_q         <= MODE_BARS;
            lfsr_q         <= LFSR_SEED;
            clear_color_q  <= 32'h0;
            w_q            <= 16'd0;
            h_q            <= 16'd0;
            b_q            <= 3'd4;
            base_q         <= 32'h0;
            addr_q         <= 32'h0;
            x_q            <= 16'd0;
            y_q            <= 16'd0;
            bar_cnt_q      <= 16'd0;
            bar_idx_q      <= 3'd0;
            mod_cnt_q      <= 4'd0;
            sx_q           <= 16'd0;
            sy_q           <= 16'd0;
            rx_q           <= 16'd0;
            ry_q           <= 16'd0;
            write_req_out  <= 1'b0;
            write_adr_out  <= '0;
            write_data_out <= 32'h0;
            write_mask_out <= '0;
        end else begin
            lfsr_q        <= {lfsr_q[30:0], lfsr_fb};
            write_req_out <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (!buttons[0]) begin
                        mode_q  <= MODE_CLEAR;
                        state_q <= ST_SETUP;
                    end else if (!buttons[1]) begin
                        mode_q  <= MODE_SNOW;
                        state_q <= ST_SETUP;
                    end else if (switches[0]) begin
                        mode_q  <= MODE_PLOT;
                        state_q <= ST_SETUP;
                    end
                end

                // Geometry is frozen here for the whole operation
                ST_SETUP: begin
                    w_q       <= DISP_bitmap_width;
                    h_q       <= DISP_bitmap_height;
                    b_q       <= pix_bytes;
                    base_q    <= DISP_mem_addr;
                    addr_q    <= DISP_mem_addr;
                    x_q       <= 16'd0;
                    y_q       <= 16'd0;
                    bar_cnt_q <= 16'd0;
                    bar_idx_q <= 3'd0;
                    mod_cnt_q <= 4'd0;
                    sx_q      <= lfsr_q[15:0];
                    sy_q      <= lfsr_q[31:16];
                    rx_q      <= 16'd0;
                    ry_q      <= 16'd0;
                    if (!geom_ok) begin
                        state_q <= ST_IDLE;
                    end else if (mode_q == MODE_PLOT) begin
                        state_q <= ST_MOD;
                    end else begin
                        state_q <= ST_FILL;
                    end
                end

                ST_FILL: begin
                    if (!write_busy_in) begin
                        write_req_out  <= 1'b1;
                        write_adr_out  <= addr_q[PORT_ADDR_SIZE-1:0];
                        write_data_out <= fill_color;
                        write_mask_out <= byte_mask;
                        addr_q         <= addr_q + {29'd0, b_q};

                        // Bar index tracks x / bar_w without a divider
                        if (x_q == w_q - 16'd1) begin
                            bar_cnt_q <= 16'd0;
                            bar_idx_q <= 3'd0;
                        end else if (bar_cnt_q == bar_w - 16'd1) begin
                            bar_cnt_q <= 16'd0;
                            if (bar_idx_q != 3'd7) begin
                                bar_idx_q <= bar_idx_q + 3'd1;
                            end
                        end else begin
                            bar_cnt_q <= bar_cnt_q + 16'd1;
                        end

                        if (x_q == w_q - 16'd1) begin
                            x_q <= 16'd0;
                            if (y_q == h_q - 16'd1) begin
                                state_q <= ST_IDLE;
                                if (mode_q == MODE_CLEAR) begin
                                    clear_color_q <= clear_color_q + CLEAR_STEP;
                                end
                            end else begin
                                y_q <= y_q + 16'd1;
                            end
                        end else begin
                            x_q <= x_q + 16'd1;
                        end
                    end
                end

                ST_MOD: begin
                    sx_q      <= {sx_q[14:0], 1'b0};
                    sy_q      <= {sy_q[14:0], 1'b0};
                    rx_q      <= rx_step;
                    ry_q      <= ry_step;
                    mod_cnt_q <= mod_cnt_q + 4'd1;
                    if (mod_cnt_q == 4'd15) begin
                        state_q <= ST_PLOT;
                    end
                end

                ST_PLOT: begin
                    if (!write_busy_in) begin
                        write_req_out  <= 1'b1;
                        write_adr_out  <= plot_addr[PORT_ADDR_SIZE-1:0];
                        write_data_out <= lfsr_q;
                        write_mask_out <= byte_mask;
                        state_q        <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_test_pattern_gen.sv
`timescale 1ns/1ps
// Randomised self-checking bench for draw_test_pattern_gen: a scoreboard of
// expected pixel writes built from the raster/colour rules, checked every cycle.
module tb_draw_test_pattern_gen;

    localparam int AW = 25;
    localparam logic [31:0] SEED = 32'hACE12468;
    localparam int K_FIX = 0, K_SNOW = 1;
    localparam int M_BARS = 0, M_CLEAR = 1, M_SNOW = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [2:0]         DISP_pixel_bytes;
    logic [31:0]        DISP_mem_addr;
    logic signed [15:0] DISP_bitmap_width, DISP_bitmap_height;
    logic               write_busy_in = 1'b0;
    logic               write_req_out;
    logic [AW-1:0]      write_adr_out;
    logic [31:0]        write_data_out;
    logic [3:0]         write_mask_out;
    logic [1:0]         buttons = 2'b11;
    logic [1:0]         switches = 2'b00;

    always #5 clk = ~clk;

    draw_test_pattern_gen #(
        .PORT_ADDR_SIZE(AW),
        .PIXEL_WIDTH   (32)
    ) dut (
        .CMD_CLK           (clk),
        .reset             (reset),
        .DISP_pixel_bytes  (DISP_pixel_bytes),
        .DISP_mem_addr     (DISP_mem_addr),
        .DISP_bitmap_width (DISP_bitmap_width),
        .DISP_bitmap_height(DISP_bitmap_height),
        .write_busy_in     (write_busy_in),
        .write_req_out     (write_req_out),
        .write_adr_out     (write_adr_out),
        .write_data_out    (write_data_out),
        .write_mask_out    (write_mask_out),
        .buttons           (buttons),
        .switches          (switches)
    );

    typedef struct {
        int            kind;
        logic [AW-1:0] adr;
        logic [31:0]   data;
        int            b;
    } exp_t;

    exp_t          q[$];
    logic [31:0]   bars[8] = '{32'hFFFFFFFF, 32'hFFFFFF00, 32'hFF00FFFF, 32'hFF00FF00,
                               32'hFFFF00FF, 32'hFFFF0000, 32'hFF0000FF, 32'hFF000000};
    int            checks = 0, failures = 0;
    logic [31:0]   m_lfsr = SEED, lfsr_pre = SEED;
    logic [31:0]   hist[$];
    logic          rst_seen = 1'b0, busy_seen = 1'b0, seen_valid = 1'b0;
    bit            plot_mode = 0;
    int            pw = 1, ph = 1, pb = 4;
    logic [31:0]   pbase = 32'h0;
    int            plot_count = 0;
    logic [31:0]   clr_model = 32'h0;
    bit            busy_rand = 0, busy_force = 0;
    logic [AW-1:0] obs_adr[$];
    logic [31:0]   obs_data[$];
    logic [3:0]    obs_mask[$];
    int            lat;
    bit            got;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic logic [31:0] bmask(input int b);
        return (b == 1) ? 32'hFF : (b == 2) ? 32'hFFFF : 32'hFFFFFFFF;
    endfunction

    // True if some LFSR value seen since the previous plot maps to this address
    function automatic bit plot_match(input logic [AW-1:0] adr);
        bit hit = 0;
        foreach (hist[i]) begin
            int x, y;
            logic [31:0] a;
            x = int'(hist[i][15:0]) % pw;
            y = int'(hist[i][31:16]) % ph;
            a = pbase + 32'((y * pw + x) * pb);
            if (a[AW-1:0] == adr) hit = 1;
        end
        return hit;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_geom(input int w, input int h, input int b, input logic [31:0] base);
        DISP_bitmap_width  = 16'(w);
        DISP_bitmap_height = 16'(h);
        DISP_pixel_bytes   = 3'(b);
        DISP_mem_addr      = base;
    endtask

    task automatic clear_obs();
        obs_adr.delete();
        obs_data.delete();
        obs_mask.delete();
    endtask

    // Expected raster of a whole fill, in issue order
    task automatic push_fill(input int mode, input int w, input int h, input int b,
                             input logic [31:0] base);
        int bw;
        exp_t e;
        bw = ((w >> 3) < 1) ? 1 : (w >> 3);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                logic [31:0] a;
                int bi;
                a = base + 32'((y * w + x) * b);
                bi = ((x / bw) > 7) ? 7 : (x / bw);
                e.adr  = a[AW-1:0];
                e.b    = b;
                e.kind = (mode == M_SNOW) ? K_SNOW : K_FIX;
                e.data = (mode == M_BARS) ? bars[bi] : clr_model;
                q.push_back(e);
            end
        end
        if (mode == M_CLEAR) clr_model = clr_model + 32'h00102030;
    endtask

    task automatic do_reset(input int w, input int h, input int b, input logic [31:0] base);
        reset = 1'b1;
        tick(2);
        q.delete();
        clear_obs();
        clr_model = 32'h0;
        set_geom(w, h, b, base);
        push_fill(M_BARS, w, h, b, base);
        reset = 1'b0;
    endtask

    task automatic wait_req(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (write_req_out) seen = 1;
        end
        chk(seen, name, 32'(seen), 32'd1);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && q.size() > 0; i++) @(negedge clk);
        chk(q.size() == 0, name, 32'(q.size()), 32'd0);
        tick(8);
    endtask

    task automatic press(input logic [1:0] btn, input string name);
        buttons = btn;
        wait_req(name, 40);
        tick(1);
        buttons = 2'b11;
    endtask

    // Model LFSR and what the DUT sampled at each rising edge
    always @(posedge clk) begin
        rst_seen   <= reset;
        busy_seen  <= write_busy_in;
        seen_valid <= 1'b1;
        lfsr_pre   <= m_lfsr;
        hist.push_back(m_lfsr);
        if (hist.size() > 64) void'(hist.pop_front());
        m_lfsr <= reset ? SEED : lfsr_step(m_lfsr);
    end

    // Busy driver: random, forced, or idle
    initial forever begin
        @(posedge clk);
        #3;
        write_busy_in = busy_rand ? ($urandom_range(0, 3) == 0) : busy_force;
    end

    // Compare process
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] expd;
        logic [31:0] bm;
        if (seen_valid) begin
            if (rst_seen) begin
                chk(!write_req_out && write_adr_out == '0 && write_data_out == 32'h0 &&
                    write_mask_out == 4'h0, "reset_outputs", write_data_out, 32'h0);
            end else begin
                if (busy_seen) chk(!write_req_out, "busy_no_req", 32'(write_req_out), 32'h0);
                if (write_req_out) begin
                    obs_adr.push_back(write_adr_out);
                    obs_data.push_back(write_data_out);
                    obs_mask.push_back(write_mask_out);
                    if (q.size() > 0) begin
                        e    = q.pop_front();
                        bm   = bmask(e.b);
                        expd = (e.kind == K_SNOW) ? lfsr_pre : e.data;
                        chk(write_adr_out == e.adr, "addr", 32'(write_adr_out), 32'(e.adr));
                        chk(write_mask_out == 4'((1 << e.b) - 1), "mask",
                            32'(write_mask_out), 32'((1 << e.b) - 1));
                        chk((write_data_out & bm) == (expd & bm), "data",
                            write_data_out & bm, expd & bm);
                    end else begin
                        chk(plot_mode, "req_expected", 32'(write_adr_out), 32'h0);
                        if (plot_mode) begin
                            bm = bmask(pb);
                            plot_count++;
                            chk(plot_match(write_adr_out), "plot_addr",
                                32'(write_adr_out), 32'h0);
                            chk(write_mask_out == 4'((1 << pb) - 1), "plot_mask",
                                32'(write_mask_out), 32'((1 << pb) - 1));
                            chk((write_data_out & bm) == (lfsr_pre & bm), "plot_data",
                                write_data_out & bm, lfsr_pre & bm);
                            hist.delete();
                        end
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        set_geom(4, 2, 4, 32'h0);

        // Reset release: 4x2 bars, first write within 3 cycles
        do_reset(4, 2, 4, 32'h0);
        lat = 0;
        got = 0;
        for (int i = 1; i <= 6 && !got; i++) begin
            @(negedge clk);
            if (write_req_out) begin
                got = 1;
                lat = i;
            end
        end
        chk(got && lat <= 3, "first_req_latency", 32'(lat), 32'd3);
        drain("bars4x2_drain", 100);
        chk(obs_adr.size() == 8, "bars4x2_count", 32'(obs_adr.size()), 32'd8);
        chk(obs_adr[7] == 25'd28, "bars4x2_last_addr", 32'(obs_adr[7]), 32'd28);
        chk(obs_data[0] == 32'hFFFFFFFF, "bars4x2_x0", obs_data[0], 32'hFFFFFFFF);
        chk(obs_data[3] == 32'hFF00FF00, "bars4x2_x3", obs_data[3], 32'hFF00FF00);
        chk(obs_mask[0] == 4'hF, "bars4x2_mask", 32'(obs_mask[0]), 32'hF);

        // Wider bars, 2 bytes/pixel, address wraps past 2^25, random busy
        busy_rand = 1;
        do_reset(64, 3, 2, 32'h01FFFFF0);
        drain("bars64_drain", 2000);
        chk(obs_adr.size() == 192, "bars64_count", 32'(obs_adr.size()), 32'd192);
        chk(obs_adr[8] == 25'h0, "bars64_wrap", 32'(obs_adr[8]), 32'h0);
        chk(obs_data[8][15:0] == 16'hFF00, "bars64_bar1", 32'(obs_data[8][15:0]), 32'hFF00);

        // Clear screen, then again with the stepped colour and a busy burst
        busy_rand = 0;
        set_geom(4, 1, 2, 32'h100);
        push_fill(M_CLEAR, 4, 1, 2, 32'h100);
        clear_obs();
        press(2'b10, "clear1_start");
        drain("clear1_drain", 100);
        chk(obs_adr[0] == 25'h100, "clear1_addr0", 32'(obs_adr[0]), 32'h100);
        chk(obs_adr[3] == 25'h106, "clear1_addr3", 32'(obs_adr[3]), 32'h106);
        chk(obs_mask[0] == 4'h3, "clear1_mask", 32'(obs_mask[0]), 32'h3);
        chk(obs_data[0][15:0] == 16'h0, "clear1_data", 32'(obs_data[0][15:0]), 32'h0);

        set_geom(8, 2, 4, 32'h40);
        push_fill(M_CLEAR, 8, 2, 4, 32'h40);
        clear_obs();
        press(2'b10, "clear2_start");
        tick(1);
        busy_force = 1;
        tick(5);
        busy_force = 0;
        drain("clear2_drain", 200);
        chk(obs_data[0] == 32'h00102030, "clear2_color", obs_data[0], 32'h00102030);
        chk(obs_adr.size() == 16, "clear2_count", 32'(obs_adr.size()), 32'd16);

        // Snow, then both buttons low: clear has priority
        busy_rand = 1;
        set_geom(5, 3, 4, 32'h2000);
        push_fill(M_SNOW, 5, 3, 4, 32'h2000);
        press(2'b01, "snow_start");
        drain("snow_drain", 500);
        set_geom(3, 2, 4, 32'h3000);
        push_fill(M_CLEAR, 3, 2, 4, 32'h3000);
        press(2'b00, "prio_start");
        drain("prio_drain", 500);

        // Non-positive geometry issues nothing
        for (int g = 0; g < 2; g++) begin
            if (g == 0) set_geom(0, 4, 4, 32'h0);
            else        set_geom(4, -2, 4, 32'h0);
            clear_obs();
            buttons = 2'b01;
            tick(6);
            buttons = 2'b11;
            tick(10);
            chk(obs_adr.size() == 0, "bad_geom_no_write", 32'(obs_adr.size()), 32'd0);
        end

        // Random single-pixel plotting
        set_geom(10, 5, 4, 32'h0);
        pw = 10;
        ph = 5;
        pb = 4;
        pbase = 32'h0;
        plot_count = 0;
        hist.delete();
        plot_mode = 1;
        switches = 2'b01;
        tick(400);
        switches = 2'b00;
        tick(60);
        plot_mode = 0;
        chk(plot_count >= 5, "plot_count", 32'(plot_count), 32'd5);

        // Reset in the middle of a fill restarts bars at BASE
        busy_rand = 0;
        do_reset(32, 4, 4, 32'h300);
        for (int i = 0; i < 400 && obs_adr.size() < 20; i++) @(negedge clk);
        chk(obs_adr.size() >= 20, "midfill_progress", 32'(obs_adr.size()), 32'd20);
        do_reset(32, 4, 4, 32'h300);
        drain("restart_drain", 400);
        chk(obs_adr[0] == 25'h300, "restart_base", 32'(obs_adr[0]), 32'h300);
        chk(obs_adr.size() == 128, "restart_count", 32'(obs_adr.size()), 32'd128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
